load_store_unit: RTL

- Initiator side of the word-wide data memory interface.
- Sits between the MEM stage and data memory. Turns one CPU load/store request (byte/half/word, signed/unsigned) into correctly spaced mem_read/mem_write strobes.
- Memory is big-endian, word-only, and edge-triggered on its strobes. Sub-word stores are done as read-modify-write; misaligned or out-of-range accesses are rejected with an error.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request and data-memory bus bundle for the load/store unit
interface load_store_unit_if;
    // CPU request side
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    // Data memory side
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata, mem_data,
        output busy, done, err, rdata, mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req, we, size, unsigned_ld, addr, wdata, mem_data,
        input  busy, done, err, rdata, mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequences byte/half/word loads and stores onto a big-endian word memory
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_STROBE,
        RD_CAPTURE,
        WR_SETUP,
        WR_STROBE,
        DONE
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic [32:0] base_end_d;
    logic        acc_err_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] ld_val_d;
    logic [31:0] merge_d;

    // Request legality check on the live inputs, and lane extract/merge on the returned word
    always_comb begin
        base_end_d = {1'b0, bus.addr[31:2], 2'b00} + 33'd3;
        acc_err_d  = (bus.size == 2'b11)
                   || (bus.size == 2'b01 && bus.addr[0])
                   || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00)
                   || (base_end_d >= MEM_LIMIT);

        // Big-endian: offset 0 is the most significant byte
        case (off_q)
            2'd0:    byte_d = bus.mem_data[31:24];
            2'd1:    byte_d = bus.mem_data[23:16];
            2'd2:    byte_d = bus.mem_data[15:8];
            default: byte_d = bus.mem_data[7:0];
        endcase
        half_d = off_q[1] ? bus.mem_data[15:0] : bus.mem_data[31:16];

        case (size_q)
            2'b00:   ld_val_d = uns_q ? {24'h0, byte_d} : {{24{byte_d[7]}}, byte_d};
            2'b01:   ld_val_d = uns_q ? {16'h0, half_d} : {{16{half_d[15]}}, half_d};
            default: ld_val_d = bus.mem_data;
        endcase

        merge_d = bus.mem_data;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merge_d[31:24] = wdata_q[7:0];
                2'd1:    merge_d[23:16] = wdata_q[7:0];
                2'd2:    merge_d[15:8]  = wdata_q[7:0];
                default: merge_d[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_d[15:0] = wdata_q;
        end else begin
            merge_d[31:16] = wdata_q;
        end
    end

    // Access sequencer: every output is registered and set on the edge entering its state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            we_q             <= 1'b0;
            size_q           <= 2'b00;
            uns_q            <= 1'b0;
            off_q            <= 2'b00;
            wdata_q          <= 16'h0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            rdata_q          <= 32'h0;
            mem_address_q    <= 32'h0;
            mem_write_data_q <= 32'h0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        size_q  <= bus.size;
                        uns_q   <= bus.unsigned_ld;
                        off_q   <= bus.addr[1:0];
                        wdata_q <= bus.wdata[15:0];
                        busy_q  <= 1'b1;
                        err_q   <= acc_err_d;
                        if (acc_err_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            mem_address_q <= {bus.addr[31:2], 2'b00};
                            if (bus.we && bus.size == 2'b10) begin
                                mem_write_data_q <= bus.wdata;
                                state_q          <= WR_SETUP;
                            end else begin
                                state_q <= RD_SETUP;
                            end
                        end
                    end
                end
                RD_SETUP: begin
                    mem_read_q <= 1'b1;
                    state_q    <= RD_STROBE;
                end
                RD_STROBE: begin
                    state_q <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    // Memory holds mem_data until the next read strobe, so it is still valid here
                    if (we_q) begin
                        mem_write_data_q <= merge_d;
                        state_q          <= WR_SETUP;
                    end else begin
                        rdata_q <= ld_val_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                WR_SETUP: begin
                    mem_write_q <= 1'b1;
                    state_q     <= WR_STROBE;
                end
                WR_STROBE: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.rdata          = rdata_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;

endmodule
